// File: rtl/div_iter_param.sv
// Iterative restoring divider, one quotient bit per cycle, with valid/ready on
// both sides, fixed divide-by-zero/overflow results and a pipeline-flush abort.
module div_iter_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Two's-complement negate; MIN maps to itself, which is its unsigned magnitude.
  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  // The partial remainder always stays below |y|, so WIDTH bits hold it; the
  // extra bit only exists in the trial subtraction.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_x;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_zero;
  logic             r_ovf;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic             w_xneg;
  logic             w_yneg;
  logic             w_accept;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Ready depends only on state and out_ready so a stalled consumer blocks issue.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Operand sign handling, restoring-step datapath and final sign fix.
  always_comb begin
    w_xneg   = div_signed & x[WIDTH-1];
    w_yneg   = div_signed & y[WIDTH-1];
    w_accept = in_valid & in_ready & ~abort;
    w_shift  = {r_rem, r_dvd[WIDTH-1]};
    w_trial  = w_shift - {1'b0, r_dvs};
    w_qbit   = ~w_trial[WIDTH];
    if (r_sign_q) begin
      w_q_fix = f_neg(r_dvd);
    end else begin
      w_q_fix = r_dvd;
    end
    if (r_sign_r) begin
      w_r_fix = f_neg(r_rem);
    end else begin
      w_r_fix = r_rem;
    end
  end

  // Control FSM and datapath registers; reset beats abort, abort beats accept.
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_rem       <= ZERO_W;
      r_dvd       <= ZERO_W;
      r_dvs       <= ZERO_W;
      r_x         <= ZERO_W;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_s         <= ZERO_W;
      r_r         <= ZERO_W;
      r_dbz       <= 1'b0;
    end else if (abort) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      // Accept happens from IDLE or from DONE while the result is consumed.
      r_state     <= ST_CALC;
      r_cnt       <= {CNT_W{1'b0}};
      r_rem       <= ZERO_W;
      r_dvd       <= w_xneg ? f_neg(x) : x;
      r_dvs       <= w_yneg ? f_neg(y) : y;
      r_x         <= x;
      r_sign_q    <= w_xneg ^ w_yneg;
      r_sign_r    <= w_xneg;
      r_zero      <= (y == ZERO_W);
      r_ovf       <= div_signed & (x == MIN_W) & (y == ONES_W);
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        ST_CALC: begin
          r_rem <= w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_FIX;
          end else begin
            r_state <= ST_CALC;
          end
        end
        ST_FIX: begin
          if (r_zero) begin
            r_s   <= ONES_W;
            r_r   <= r_x;
            r_dbz <= 1'b1;
          end else if (r_ovf) begin
            r_s   <= MIN_W;
            r_r   <= ZERO_W;
            r_dbz <= 1'b0;
          end else begin
            r_s   <= w_q_fix;
            r_r   <= w_r_fix;
            r_dbz <= 1'b0;
          end
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign s           = r_s;
  assign r           = r_r;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_iter_param.sv
// Directed bench for div_iter_param at WIDTH=32 plus a randomised WIDTH=8
// instance checked against a behavioural division model.
module tb_div_iter_param;

  logic        div_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        div_signed = 1'b0;
  logic [31:0] x = 32'd0;
  logic [31:0] y = 32'd0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] s;
  logic [31:0] r;
  logic        div_by_zero;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic        div_signed8 = 1'b0;
  logic [7:0]  x8 = 8'd0;
  logic [7:0]  y8 = 8'd0;
  logic        abort8 = 1'b0;
  logic        out_valid8;
  logic        out_ready8 = 1'b0;
  logic [7:0]  s8;
  logic [7:0]  r8;
  logic        dbz8;

  int checks = 0;
  int failures = 0;

  always #5 div_clk = ~div_clk;

  div_iter_param #(.WIDTH(32)) dut (
    .div_clk(div_clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .div_signed(div_signed), .x(x), .y(y), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .r(r), .div_by_zero(div_by_zero)
  );

  div_iter_param #(.WIDTH(8)) dut8 (
    .div_clk(div_clk), .resetn(resetn), .in_valid(in_valid8), .in_ready(in_ready8),
    .div_signed(div_signed8), .x(x8), .y(y8), .abort(abort8), .out_valid(out_valid8),
    .out_ready(out_ready8), .s(s8), .r(r8), .div_by_zero(dbz8)
  );

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  // Presents an op and lets it be accepted on the next edge where in_ready is high.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, output bit ok);
    int n;
    n = 0;
    div_signed = sgn; x = a; y = b; in_valid = 1'b1;
    while (!in_ready && n < 100) begin tick(); n++; end
    ok = in_ready;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin tick(); cyc++; end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (s !== 32'd0) begin failures++; $display("FAIL reset_s: got %h expected 0", s); end
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL reset_r: got %h expected 0", r); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
  endtask

  // Accept edge T, out_valid first seen after edge T+33 for WIDTH=32.
  task automatic test_unsigned();
    bit ok; int cyc;
    start_op(1'b0, 32'd100, 32'd7, ok);
    checks++; if (!ok) begin failures++; $display("FAIL uns_accept: got 0 expected 1"); end
    wait_result(cyc);
    checks++; if (cyc !== 33) begin failures++; $display("FAIL uns_latency: got %0d expected 33", cyc); end
    checks++; if (s !== 32'd14) begin failures++; $display("FAIL uns_s: got %h expected %h", s, 32'd14); end
    checks++; if (r !== 32'd2) begin failures++; $display("FAIL uns_r: got %h expected %h", r, 32'd2); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL uns_dbz: got %b expected 0", div_by_zero); end
    take();
  endtask

  task automatic test_signed();
    bit ok; int cyc;
    start_op(1'b1, 32'hFFFFFFF9, 32'd2, ok);
    wait_result(cyc);
    checks++; if (s !== 32'hFFFFFFFD) begin failures++; $display("FAIL sgn1_s: got %h expected fffffffd", s); end
    checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL sgn1_r: got %h expected ffffffff", r); end
    take();
    start_op(1'b1, 32'd7, 32'hFFFFFFFE, ok);
    wait_result(cyc);
    checks++; if (s !== 32'hFFFFFFFD) begin failures++; $display("FAIL sgn2_s: got %h expected fffffffd", s); end
    checks++; if (r !== 32'd1) begin failures++; $display("FAIL sgn2_r: got %h expected 1", r); end
    take();
    start_op(1'b1, 32'hFFFFFF9C, 32'd7, ok);
    wait_result(cyc);
    checks++; if (s !== 32'hFFFFFFF2) begin failures++; $display("FAIL sgn3_s: got %h expected fffffff2", s); end
    checks++; if (r !== 32'hFFFFFFFE) begin failures++; $display("FAIL sgn3_r: got %h expected fffffffe", r); end
    take();
  endtask

  task automatic test_div_zero_ovf();
    bit ok; int cyc;
    for (int m = 0; m < 2; m++) begin
      start_op(m[0], 32'd5, 32'd0, ok);
      wait_result(cyc);
      checks++; if (cyc !== 33) begin failures++; $display("FAIL dz_latency mode=%0d: got %0d expected 33", m, cyc); end
      checks++; if (s !== 32'hFFFFFFFF) begin failures++; $display("FAIL dz_s mode=%0d: got %h expected ffffffff", m, s); end
      checks++; if (r !== 32'd5) begin failures++; $display("FAIL dz_r mode=%0d: got %h expected 5", m, r); end
      checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_flag mode=%0d: got %b expected 1", m, div_by_zero); end
      take();
    end
    start_op(1'b1, 32'h80000000, 32'hFFFFFFFF, ok);
    wait_result(cyc);
    checks++; if (cyc !== 33) begin failures++; $display("FAIL ovf_latency: got %0d expected 33", cyc); end
    checks++; if (s !== 32'h80000000) begin failures++; $display("FAIL ovf_s: got %h expected 80000000", s); end
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL ovf_r: got %h expected 0", r); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL ovf_dbz: got %b expected 0", div_by_zero); end
    take();
    start_op(1'b0, 32'h80000000, 32'hFFFFFFFF, ok);
    wait_result(cyc);
    checks++; if (s !== 32'd0) begin failures++; $display("FAIL uns_big_s: got %h expected 0", s); end
    checks++; if (r !== 32'h80000000) begin failures++; $display("FAIL uns_big_r: got %h expected 80000000", r); end
    take();
  endtask

  task automatic test_backpressure();
    bit ok; int cyc;
    start_op(1'b0, 32'd1000, 32'd10, ok);
    wait_result(cyc);
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || s !== 32'd100 || r !== 32'd0) begin
        failures++; $display("FAIL bp_hold k=%0d: got v=%b s=%h r=%h expected v=1 s=64 r=0", k, out_valid, s, r);
      end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready k=%0d: got %b expected 0", k, in_ready); end
    end
    div_signed = 1'b0; x = 32'd50; y = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_follow: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_reissue: got v=%b rdy=%b expected v=0 rdy=0", out_valid, in_ready);
    end
    wait_result(cyc);
    checks++; if (cyc !== 33) begin failures++; $display("FAIL bp_latency: got %0d expected 33", cyc); end
    checks++; if (s !== 32'd7 || r !== 32'd1) begin failures++; $display("FAIL bp_result: got s=%h r=%h expected s=7 r=1", s, r); end
    take();
  endtask

  // With out_ready held high results arrive every WIDTH+2 = 34 cycles.
  task automatic test_back_to_back();
    int cyc;
    div_signed = 1'b0; x = 32'd1000; y = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 100) begin tick(); cyc++; end
    checks++; if (s !== 32'd333 || r !== 32'd1) begin failures++; $display("FAIL b2b_first: got s=%h r=%h expected s=14d r=1", s, r); end
    tick();
    cyc = 1;
    while (!out_valid && cyc < 100) begin tick(); cyc++; end
    checks++; if (cyc !== 34) begin failures++; $display("FAIL b2b_period: got %0d expected 34", cyc); end
    checks++; if (s !== 32'd333 || r !== 32'd1) begin failures++; $display("FAIL b2b_second: got s=%h r=%h expected s=14d r=1", s, r); end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_drain: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_abort();
    bit ok, seen; int cyc;
    start_op(1'b0, 32'd12345, 32'd3, ok);
    repeat (9) tick();
    abort = 1'b1; in_valid = 1'b1; x = 32'd9; y = 32'd3;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL abort_calc: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin tick(); if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_result: got out_valid seen=1 expected 0"); end
    abort = 1'b1; in_valid = 1'b1; x = 32'd20; y = 32'd4;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_idle_ready: got %b expected 1", in_ready); end
    seen = 1'b0;
    repeat (40) begin tick(); if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_suppress_accept: got out_valid seen=1 expected 0"); end
    start_op(1'b0, 32'hFFFFFFFF, 32'd1, ok);
    wait_result(cyc);
    checks++; if (cyc !== 33) begin failures++; $display("FAIL abort_next_latency: got %0d expected 33", cyc); end
    checks++; if (s !== 32'hFFFFFFFF || r !== 32'd0) begin failures++; $display("FAIL abort_next_result: got s=%h r=%h expected s=ffffffff r=0", s, r); end
    take();
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    start_op(1'b1, 32'hFFFFFF9C, 32'd7, ok);
    repeat (5) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL midreset_state: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
    checks++; if (s !== 32'd0 || r !== 32'd0 || div_by_zero !== 1'b0) begin
      failures++; $display("FAIL midreset_outs: got s=%h r=%h z=%b expected all 0", s, r, div_by_zero);
    end
    seen = 1'b0;
    repeat (40) begin tick(); if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_result: got out_valid seen=1 expected 0"); end
  endtask

  task automatic test_random8();
    logic [7:0] a, b, es, er;
    logic signed [7:0] sa, sb;
    logic sgn, ez;
    int n;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      sgn = 1'($urandom_range(0, 1));
      if (i % 17 == 0) b = 8'd0;
      if (i % 23 == 0) begin a = 8'h80; b = 8'hFF; sgn = 1'b1; end
      sa = a; sb = b;
      if (b == 8'd0) begin es = 8'hFF; er = a; ez = 1'b1; end
      else if (sgn && a == 8'h80 && b == 8'hFF) begin es = 8'h80; er = 8'd0; ez = 1'b0; end
      else if (sgn) begin es = 8'(sa / sb); er = 8'(sa % sb); ez = 1'b0; end
      else begin es = a / b; er = a % b; ez = 1'b0; end
      div_signed8 = sgn; x8 = a; y8 = b; in_valid8 = 1'b1;
      n = 0;
      while (!in_ready8 && n < 50) begin tick(); n++; end
      tick();
      in_valid8 = 1'b0;
      n = 0;
      while (!out_valid8 && n < 50) begin tick(); n++; end
      checks++; if (n !== 9) begin failures++; $display("FAIL w8_latency i=%0d: got %0d expected 9", i, n); end
      checks++; if (s8 !== es || r8 !== er || dbz8 !== ez) begin
        failures++; $display("FAIL w8_result i=%0d sgn=%b %h/%h: got s=%h r=%h z=%b expected s=%h r=%h z=%b",
                             i, sgn, a, b, s8, r8, dbz8, es, er, ez);
      end
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero_ovf();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
